// File: rtl/hamming_sec_engine_pkg.sv
// Shared types and helpers for the Hamming(15,11) single-error-correcting decoder engine.
package hamming_sec_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    CAP,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  // Parity bit positions inside c[15:1]
  localparam int P1 = 1;
  localparam int P2 = 2;
  localparam int P4 = 4;
  localparam int P8 = 8;

  function automatic logic [3:0] syndrome15(input logic [15:1] c);
    logic [3:0] s;
    s = '0;
    for (int j = 1; j <= 15; j++) begin
      if ((j & P1) != 0) s[0] = s[0] ^ c[j];
      if ((j & P2) != 0) s[1] = s[1] ^ c[j];
      if ((j & P4) != 0) s[2] = s[2] ^ c[j];
      if ((j & P8) != 0) s[3] = s[3] ^ c[j];
    end
    return s;
  endfunction

endpackage

// File: rtl/hamming_sec_engine_if.sv
// Control handshake and data-memory port shared by the decoder engine and its memory/host side.
interface hamming_sec_engine_if #(
  parameter int AW = 8
);
  logic          start;
  logic          halt;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [7:0]    mem_rdata;
  logic          mem_wr_en;
  logic [7:0]    mem_wdata;
  logic [3:0]    err_cnt;

  modport master (
    input  start, mem_rdata,
    output halt, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, err_cnt
  );

  modport slave (
    output start, mem_rdata,
    input  halt, mem_addr, mem_rd_en, mem_wr_en, mem_wdata, err_cnt
  );
endinterface

// File: rtl/hamming_sec_engine_sec.sv
// Combinational Hamming(15,11) corrector: flips the bit named by the syndrome and extracts the data.
module hamming_sec_engine_sec
  import hamming_sec_engine_pkg::*;
(
  input  logic [15:1] cw,
  output logic [11:1] data,
  output logic [3:0]  syn,
  output logic        corrected
);

  logic [15:1] fixed;

  always_comb begin
    syn       = syndrome15(cw);
    corrected = (syn != 4'd0);
    for (int j = 1; j <= 15; j++) begin
      fixed[j] = cw[j] ^ (syn == 4'(j));
    end
    data = {fixed[15:P8+1], fixed[P8-1:P4+1], fixed[P4-1]};
  end

endmodule

// File: rtl/hamming_sec_engine.sv
// Bus-master engine: reads N_WORDS codewords, corrects single-bit errors, writes 11-bit messages back.
module hamming_sec_engine
  import hamming_sec_engine_pkg::*;
#(
  parameter int AW       = 8,
  parameter int SRC_BASE = 64,
  parameter int DST_BASE = 94,
  parameter int N_WORDS  = 15
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  hamming_sec_engine_if.master bus
);

  localparam logic [3:0] LAST_IDX = 4'(N_WORDS - 1);

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    err_q, err_d;
  logic [15:1]   cw_q, cw_d;
  logic          halt_q, halt_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;

  logic [11:1]   dec_data;
  logic [3:0]    syn_unused;
  logic          dec_corr;
  logic          unused_rdata7;

  assign unused_rdata7 = bus.mem_rdata[7];

  function automatic logic [AW-1:0] word_addr(input int base, input logic [3:0] i,
                                              input logic hi);
    return AW'(base) + AW'({i, hi});
  endfunction

  // Decoder sees the codeword as it will be after this edge, so write data can be registered.
  hamming_sec_engine_sec u_sec (
    .cw        (cw_d),
    .data      (dec_data),
    .syn       (syn_unused),
    .corrected (dec_corr)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    cw_d    = cw_q;
    halt_d  = halt_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RD_LO;
          idx_d   = '0;
          err_d   = '0;
          halt_d  = 1'b0;
          rd_d    = 1'b1;
          addr_d  = word_addr(SRC_BASE, 4'd0, 1'b0);
        end
      end
      RD_LO: begin
        state_d = RD_HI;
        rd_d    = 1'b1;
        addr_d  = word_addr(SRC_BASE, idx_q, 1'b1);
      end
      RD_HI: begin
        state_d   = CAP;
        cw_d[8:1] = bus.mem_rdata;
      end
      CAP: begin
        state_d    = WR_LO;
        cw_d[15:9] = bus.mem_rdata[6:0];
        wr_d       = 1'b1;
        addr_d     = word_addr(DST_BASE, idx_q, 1'b0);
        wdata_d    = dec_data[8:1];
        if (dec_corr && err_q != 4'd15) err_d = err_q + 4'd1;
      end
      WR_LO: begin
        state_d = WR_HI;
        wr_d    = 1'b1;
        addr_d  = word_addr(DST_BASE, idx_q, 1'b1);
        wdata_d = {5'b0, dec_data[11:9]};
      end
      WR_HI: begin
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          halt_d  = 1'b1;
        end else begin
          state_d = RD_LO;
          idx_d   = idx_q + 4'd1;
          rd_d    = 1'b1;
          addr_d  = word_addr(SRC_BASE, idx_q + 4'd1, 1'b0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      cw_q    <= '0;
      halt_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cw_q    <= cw_d;
      halt_q  <= halt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.halt      = halt_q;
  assign bus.mem_rd_en = rd_q;
  assign bus.mem_wr_en = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_hamming_sec_engine.sv
// Directed bench for hamming_sec_engine: source memory model, write scoreboard, latency and protocol checks.
module tb_hamming_sec_engine;

  localparam int AW  = 8;
  localparam int SRC = 64;
  localparam int DST = 94;
  localparam int NW  = 15;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       CLK;
  logic       reset_n;
  logic [7:0] src_mem [256];
  wr_t        exp_q[$];
  int         errors  = 0;
  int         checks  = 0;
  int         rd_cnt  = 0;
  int         exp_err = 0;

  hamming_sec_engine_if #(.AW(AW)) bus ();

  hamming_sec_engine #(
    .AW(AW), .SRC_BASE(SRC), .DST_BASE(DST), .N_WORDS(NW)
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory read port: data available one cycle after the strobe
  always @(posedge CLK) begin
    if (bus.mem_rd_en) bus.mem_rdata <= src_mem[bus.mem_addr];
  end

  function automatic logic [15:1] encode(input logic [10:0] d);
    logic [15:1] c;
    c        = '0;
    c[3]     = d[0];
    c[7:5]   = d[3:1];
    c[15:9]  = d[10:4];
    c[1] = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15];
    c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15];
    c[4] = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[8] = c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input int i, input logic [10:0] d, input int flip, input bit b7);
    logic [15:1] c;
    wr_t e;
    c = encode(d);
    if (flip != 0) c[flip] = ~c[flip];
    src_mem[SRC + 2*i]     = c[8:1];
    src_mem[SRC + 2*i + 1] = {b7, c[15:9]};
    e.a = 8'(DST + 2*i);     e.d = d[7:0];              exp_q.push_back(e);
    e.a = 8'(DST + 2*i + 1); e.d = {5'b0, d[10:8]};     exp_q.push_back(e);
    if (flip != 0) exp_err++;
  endtask

  task automatic new_run();
    exp_q.delete();
    exp_err = 0;
  endtask

  // One clock: sample after the edge, check port exclusivity, read order and scoreboard writes
  task automatic tick();
    wr_t e;
    @(posedge CLK);
    #1;
    if (!reset_n || bus.halt) rd_cnt = 0;
    chk("rd_wr_exclusive", 32'(bus.mem_rd_en & bus.mem_wr_en), 0);
    if (bus.mem_rd_en) begin
      chk("rd_addr", 32'(bus.mem_addr), 32'(8'(SRC + rd_cnt)));
      rd_cnt++;
    end
    if (bus.mem_wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 32'(bus.mem_wr_en), 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e.a));
        chk("wr_data", 32'(bus.mem_wdata), 32'(e.d));
      end
    end
  endtask

  task automatic run(input bit inject);
    int cyc;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (bus.halt !== 1'b1 && cyc < 300) begin
      bus.start = inject && (cyc == 20);
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    chk("halt_latency", cyc, 76);
    chk("err_cnt", 32'(bus.err_cnt), exp_err);
    chk("writes_left", exp_q.size(), 0);
    bus.start = inject;
    tick();
    bus.start = 1'b0;
    chk("halt_held_done", 32'(bus.halt), 1);
    tick();
    chk("halt_held_idle", 32'(bus.halt), 1);
    chk("idle_no_read", 32'(bus.mem_rd_en), 0);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_halt"},  32'(bus.halt), 0);
    chk({pfx, "_rd_en"}, 32'(bus.mem_rd_en), 0);
    chk({pfx, "_wr_en"}, 32'(bus.mem_wr_en), 0);
    chk({pfx, "_addr"},  32'(bus.mem_addr), 0);
    chk({pfx, "_wdata"}, 32'(bus.mem_wdata), 0);
    chk({pfx, "_err"},   32'(bus.err_cnt), 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    for (int a = 0; a < 256; a++) src_mem[a] = 8'h00;
    repeat (3) tick();
    chk_all_zero("reset");
    reset_n = 1'b1;
    tick();

    // All-zero message, no errors
    new_run();
    for (int i = 0; i < NW; i++) load_word(i, 11'h000, 0, 1'b0);
    run(1'b0);

    // Zero message with c5 flipped in word 0
    new_run();
    load_word(0, 11'h000, 5, 1'b0);
    for (int i = 1; i < NW; i++) load_word(i, 11'h000, 0, 1'b0);
    run(1'b0);

    // All-ones message with parity bit c8 flipped, remaining words clean random
    new_run();
    load_word(0, 11'h7FF, 8, 1'b0);
    for (int i = 1; i < NW; i++) load_word(i, 11'($urandom), 0, 1'($urandom));
    run(1'b0);

    // Random data, every flip position, stray bit 7, start pulses mid-run and in DONE
    new_run();
    for (int i = 0; i < NW; i++)
      load_word(i, 11'($urandom), (i == 0) ? 15 : $urandom_range(0, 15), (i % 3) == 0);
    run(1'b1);

    // Reset in the middle of a run
    new_run();
    for (int i = 0; i < NW; i++) load_word(i, 11'($urandom), $urandom_range(0, 15), 1'b1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (29) tick();
    reset_n = 1'b0;
    tick();
    chk_all_zero("midrun_reset");
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    repeat (15) tick();
    chk_all_zero("after_reset_idle");

    // Clean run after the abort
    new_run();
    for (int i = 0; i < NW; i++) load_word(i, 11'($urandom), $urandom_range(1, 15), 1'($urandom));
    run(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
